// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader
// Brief    : UART boot loader that writes a framed, XOR-checked program
//            image into data memory and gates the CPU until the load succeeds.
//            Optional inter-byte timeout enabled by macro LOADER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader #(
  parameter int          CLKS_PER_BIT   = 434,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MAX_WORDS      = 512,
  parameter int          TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        wr_valid,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        load_active,
  output logic        cpu_run,
  output logic        load_err,
  output logic [1:0]  err_code
);

  localparam int c_CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]        c_MAX_WORDS = 16'(MAX_WORDS);
  localparam logic [7:0]         c_MAGIC     = 8'hA5;

  localparam logic [1:0] c_RX_IDLE  = 2'd0;
  localparam logic [1:0] c_RX_START = 2'd1;
  localparam logic [1:0] c_RX_DATA  = 2'd2;
  localparam logic [1:0] c_RX_STOP  = 2'd3;

  localparam logic [2:0] c_WAIT_MAGIC = 3'd0;
  localparam logic [2:0] c_LEN0       = 3'd1;
  localparam logic [2:0] c_LEN1       = 3'd2;
  localparam logic [2:0] c_DATA       = 3'd3;
  localparam logic [2:0] c_CSUM       = 3'd4;
  localparam logic [2:0] c_DONE       = 3'd5;

  // RX front end
  logic               r_sync1;
  logic               r_sync2;
  logic               r_rx_prev;
  logic [1:0]         r_rx_state;
  logic [c_CNT_W-1:0] r_clk_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_byte_valid;
  logic               r_frame_err;

  // Frame FSM
  logic [2:0]  r_state;
  logic [7:0]  r_len_lo;
  logic [15:0] r_words;
  logic [31:0] r_addr;
  logic [31:0] r_word;
  logic [1:0]  r_byte_idx;
  logic [7:0]  r_xor;
  logic        r_wr_valid;
  logic [31:0] r_wr_addr;
  logic [31:0] r_wr_data;
  logic        r_load_active;
  logic        r_cpu_run;
  logic        r_load_err;
  logic [1:0]  r_err_code;

  logic [15:0] w_len;
  logic [31:0] w_word_next;
  logic        w_in_frame;
  logic        w_timeout;
  logic        w_abort;
  logic [1:0]  w_abort_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= uart_rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // Only a true high-to-low edge starts a byte, so a line held low after a
  // framing error cannot retrigger the receiver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state   <= c_RX_IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        c_RX_IDLE: begin
          if (r_rx_prev && !r_sync2) begin
            r_rx_state <= c_RX_START;
            r_clk_cnt  <= '0;
          end
        end
        c_RX_START: begin
          if (r_clk_cnt == c_HALF_LAST) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_rx_state <= r_sync2 ? c_RX_IDLE : c_RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        c_RX_DATA: begin
          if (r_clk_cnt == c_BIT_LAST) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_sync2, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_rx_state <= c_RX_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        c_RX_STOP: begin
          if (r_clk_cnt == c_BIT_LAST) begin
            r_clk_cnt    <= '0;
            r_rx_state   <= c_RX_IDLE;
            r_byte_valid <= r_sync2;
            r_frame_err  <= !r_sync2;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_rx_state <= c_RX_IDLE;
      endcase
    end
  end

  assign w_len       = {r_shift, r_len_lo};
  assign w_word_next = {r_shift, r_word[31:8]};
  assign w_in_frame  = (r_state != c_WAIT_MAGIC) && (r_state != c_DONE);

`ifdef LOADER_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
  logic [c_TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (r_byte_valid || !w_in_frame) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != c_TO_LAST) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = w_in_frame && (r_to_cnt == c_TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // Line errors while hunting for the magic byte are just noise and ignored.
  always_comb begin
    w_abort      = 1'b0;
    w_abort_code = 2'd0;
    if (r_byte_valid && (r_state == c_LEN1) && (w_len > c_MAX_WORDS)) begin
      w_abort      = 1'b1;
      w_abort_code = 2'd2;
    end
    if (r_byte_valid && (r_state == c_CSUM) && (r_shift != r_xor)) begin
      w_abort      = 1'b1;
      w_abort_code = 2'd1;
    end
    if ((r_frame_err || w_timeout) && w_in_frame) begin
      w_abort      = 1'b1;
      w_abort_code = 2'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_WAIT_MAGIC;
      r_len_lo      <= '0;
      r_words       <= '0;
      r_addr        <= '0;
      r_word        <= '0;
      r_byte_idx    <= '0;
      r_xor         <= '0;
      r_wr_valid    <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_load_active <= 1'b0;
      r_cpu_run     <= 1'b0;
      r_load_err    <= 1'b0;
      r_err_code    <= 2'd0;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_abort) begin
        r_state       <= c_WAIT_MAGIC;
        r_load_active <= 1'b0;
        r_cpu_run     <= 1'b0;
        r_load_err    <= 1'b1;
        r_err_code    <= w_abort_code;
      end else begin
        case (r_state)
          c_WAIT_MAGIC: begin
            if (r_byte_valid && (r_shift == c_MAGIC)) begin
              r_state       <= c_LEN0;
              r_load_active <= 1'b1;
              r_cpu_run     <= 1'b0;
              r_load_err    <= 1'b0;
              r_err_code    <= 2'd0;
            end
          end
          c_LEN0: begin
            if (r_byte_valid) begin
              r_len_lo <= r_shift;
              r_state  <= c_LEN1;
            end
          end
          c_LEN1: begin
            if (r_byte_valid) begin
              r_xor      <= '0;
              r_addr     <= BASE_ADDR;
              r_words    <= w_len;
              r_byte_idx <= '0;
              r_state    <= (w_len == 16'd0) ? c_CSUM : c_DATA;
            end
          end
          c_DATA: begin
            if (r_byte_valid) begin
              r_xor      <= r_xor ^ r_shift;
              r_word     <= w_word_next;
              r_byte_idx <= r_byte_idx + 1'b1;
              if (r_byte_idx == 2'd3) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_addr;
                r_wr_data  <= w_word_next;
                r_addr     <= r_addr + 32'd4;
                r_words    <= r_words - 1'b1;
                if (r_words == 16'd1) begin
                  r_state <= c_CSUM;
                end
              end
            end
          end
          c_CSUM: begin
            if (r_byte_valid) begin
              r_state       <= c_DONE;
              r_load_active <= 1'b0;
              r_cpu_run     <= 1'b1;
            end
          end
          c_DONE:  r_state <= c_WAIT_MAGIC;
          default: r_state <= c_WAIT_MAGIC;
        endcase
      end
    end
  end

  assign wr_valid    = r_wr_valid;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign load_active = r_load_active;
  assign cpu_run     = r_cpu_run;
  assign load_err    = r_load_err;
  assign err_code    = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_loader
// Brief    : Directed self-checking bench for mem_loader (CLKS_PER_BIT = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_loader;

  localparam int c_CPB = 16;

  logic        clk;
  logic        rst_n;
  logic        uart_rx;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        load_active;
  logic        cpu_run;
  logic        load_err;
  logic [1:0]  err_code;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          nw      = 0;
  logic [31:0] wa [8];
  logic [31:0] wd [8];
  logic [7:0]  tx_q [$];

  mem_loader #(
    .CLKS_PER_BIT   (c_CPB),
    .BASE_ADDR      (32'h0000_0000),
    .MAX_WORDS      (512),
    .TIMEOUT_CYCLES (1000)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .load_active (load_active),
    .cpu_run     (cpu_run),
    .load_err    (load_err),
    .err_code    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      if (nw < 8) begin
        wa[nw] = wr_addr;
        wd[nw] = wr_data;
      end
      nw = nw + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (c_CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (c_CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (c_CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (c_CPB) @(negedge clk);
  endtask

  task automatic send_q();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_load_active", 32'(load_active), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Two-word image; checksum 0x2A is the XOR of the eight data bytes
    nw = 0;
    tx_q = '{8'hA5, 8'h02, 8'h00};
    send_q();
    check("f1_active_mid", 32'(load_active), 32'd1);
    tx_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    send_q();
    check("f1_nwrites", 32'(nw), 32'd2);
    check("f1_addr0", wa[0], 32'h0000_0000);
    check("f1_data0", wd[0], 32'h1234_5678);
    check("f1_addr1", wa[1], 32'h0000_0004);
    check("f1_data1", wd[1], 32'hDEAD_BEEF);
    check("f1_cpu_run", 32'(cpu_run), 32'd1);
    check("f1_load_err", 32'(load_err), 32'd0);
    check("f1_load_active", 32'(load_active), 32'd0);

    // Same image with a bad checksum
    nw = 0;
    tx_q = '{8'hA5, 8'h02, 8'h00};
    send_q();
    check("f2_active_mid", 32'(load_active), 32'd1);
    check("f2_cpu_run_drop", 32'(cpu_run), 32'd0);
    tx_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
    send_q();
    check("f2_nwrites", 32'(nw), 32'd2);
    check("f2_data1", wd[1], 32'hDEAD_BEEF);
    check("f2_load_err", 32'(load_err), 32'd1);
    check("f2_err_code", 32'(err_code), 32'd1);
    check("f2_cpu_run", 32'(cpu_run), 32'd0);
    check("f2_load_active", 32'(load_active), 32'd0);

    // Count 513 exceeds MAX_WORDS
    nw = 0;
    tx_q = '{8'hA5, 8'h01, 8'h02};
    send_q();
    check("len_nwrites", 32'(nw), 32'd0);
    check("len_err_code", 32'(err_code), 32'd2);
    check("len_load_err", 32'(load_err), 32'd1);
    check("len_load_active", 32'(load_active), 32'd0);
    tx_q = '{8'hA5};
    send_q();
    check("magic_clears_err", 32'(load_err), 32'd0);
    check("magic_clears_code", 32'(err_code), 32'd0);

    // Framing error on the length-low byte
    send_byte(8'h02, 1'b0);
    repeat (10) @(negedge clk);
    check("frm_err_code", 32'(err_code), 32'd3);
    check("frm_load_err", 32'(load_err), 32'd1);
    check("frm_load_active", 32'(load_active), 32'd0);

    // Junk before magic, then an empty image with checksum 0
    nw = 0;
    tx_q = '{8'h11, 8'h22};
    send_q();
    check("junk_ignored_active", 32'(load_active), 32'd0);
    check("junk_ignored_err", 32'(load_err), 32'd1);
    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_q();
    check("empty_nwrites", 32'(nw), 32'd0);
    check("empty_cpu_run", 32'(cpu_run), 32'd1);
    check("empty_load_err", 32'(load_err), 32'd0);

    // One-cycle low glitch on the idle line
    @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (4 * c_CPB) @(negedge clk);
    check("glitch_active", 32'(load_active), 32'd0);
    check("glitch_cpu_run", 32'(cpu_run), 32'd1);

    // Reset mid-frame, then a clean one-word image (csum 0x44)
    nw = 0;
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56};
    send_q();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mrst_load_active", 32'(load_active), 32'd0);
    check("mrst_cpu_run", 32'(cpu_run), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
    send_q();
    check("mrst_nwrites", 32'(nw), 32'd1);
    check("mrst_addr0", wa[0], 32'h0000_0000);
    check("mrst_data0", wd[0], 32'h1122_3344);
    check("mrst_cpu_run_after", 32'(cpu_run), 32'd1);

`ifdef LOADER_TIMEOUT_EN
    nw = 0;
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h78};
    send_q();
    repeat (1100) @(negedge clk);
    check("to_err_code", 32'(err_code), 32'd3);
    check("to_load_active", 32'(load_active), 32'd0);
    check("to_nwrites", 32'(nw), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
